// File: rtl/seg7_pkg.sv
// seg7_pkg: scan FSM state type, blank segment pattern and counter-width helper
package seg7_pkg;
    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    function automatic int cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: load/bcd_in/lz_blank_en in, seg/dig_en/frame_done out; master drives, slave is the controller
interface seg7_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    lz_blank_en;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_done;
    modport master(output load, bcd_in, lz_blank_en, input seg, dig_en, frame_done);
    modport slave(input load, bcd_in, lz_blank_en, output seg, dig_en, frame_done);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: bcd[3:0] -> seg[6:0] (a..g, seg[6]=a, active-high), 10..15 blank
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: clk, rst_n (async low), bus slave; scans NUM_DIGITS digits with dead time, frame-synchronous double-buffered value
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
)(
    input logic              clk,
    input logic              rst_n,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int CW = cnt_w(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int W  = 4 * NUM_DIGITS;

    state_t                state, state_nx, eff;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic [W-1:0]          active, active_nx, shadow;
    logic                  pending;
    logic [3:0]            nib;
    logic [6:0]            dec, seg_q, seg_nx;
    logic [NUM_DIGITS-1:0] dig_q, dig_nx, hi_zero;
    logic                  fd_q, fd_nx, drv, slot_end, supp;

    assign eff = (BLANK_CYCLES == 0) ? ST_DRIVE : state;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_hz
        assign hi_zero[i] = ~|active_nx[W-1:4*i];
    end

    assign nib = active_nx[4*idx +: 4];

    seg7_decoder u_dec (
        .bcd (nib),
        .seg (dec)
    );

    always_comb begin
        drv       = eff == ST_DRIVE;
        slot_end  = drv && int'(cnt) == REFRESH_DIV - 1;
        cnt_nx    = slot_end ? '0 : cnt + 1'b1;
        idx_nx    = !slot_end ? idx : (int'(idx) == NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        state_nx  = slot_end ? ((BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK)
                  : (!drv && int'(cnt) == BLANK_CYCLES - 1) ? ST_DRIVE : eff;
        active_nx = !fd_q ? active : bus.load ? bus.bcd_in : pending ? shadow : active;
        supp      = bus.lz_blank_en && idx != '0 && hi_zero[idx];
        seg_nx    = (drv && !supp) ? dec : SEG_BLANK;
        dig_nx    = drv ? NUM_DIGITS'(1) << idx : '0;
        fd_nx     = slot_end && int'(idx) == NUM_DIGITS - 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
            seg_q <= SEG_BLANK;
            dig_q <= '0;
            fd_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            seg_q <= seg_nx;
            dig_q <= dig_nx;
            fd_q  <= fd_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            active  <= active_nx;
            shadow  <= (bus.load && !fd_q) ? bus.bcd_in : shadow;
            pending <= fd_q ? 1'b0 : (bus.load || pending);
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_en     = dig_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: random and directed scoreboard bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = ND * RD;

    typedef struct {
        logic [6:0]    seg;
        logic [ND-1:0] dig;
        logic          fd;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    exp_t q[$];
    int nchk = 0, nfail = 0, nmon = 0, npush = 0, ndrop = 0, k = 0;
    logic [15:0] m_act = '0, m_sh = '0;
    logic m_pend = 1'b0, lz_cur = 1'b0;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int n);
        case (n)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic exp_t predict(input int c);
        exp_t e;
        int pos, d, nibv;
        logic [15:0] hi;
        pos  = c % FR;
        d    = pos / RD;
        hi   = m_act >> (4 * d);
        nibv = int'(hi[3:0]);
        e.cyc = c;
        e.fd  = pos == FR - 1;
        if (pos % RD < BC) begin
            e.seg = '0;
            e.dig = '0;
        end else begin
            e.dig = ND'(1) << d;
            e.seg = (lz_cur && d > 0 && hi == 16'h0) ? 7'b0 : ref_seg(nibv);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [15:0] v, input logic lz);
        bus.load = ld;
        bus.bcd_in = v;
        bus.lz_blank_en = lz;
        lz_cur = lz;
        if (k > 0 && (k - 1) % FR == FR - 1) begin
            m_act = ld ? v : (m_pend ? m_sh : m_act);
            m_pend = 1'b0;
        end else if (ld) begin
            m_sh = v;
            m_pend = 1'b1;
        end
        q.push_back(predict(k));
        npush++;
        k++;
    endtask

    task automatic tick(input logic ld, input logic [15:0] v, input logic lz);
        @(posedge clk);
        #2;
        if (ld && k % FR == 0) chk("frame_done_at_boundary_load", bus.frame_done, 1);
        drive(ld, v, lz);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 16'h0, lz_cur);
    endtask

    task automatic idle_to(input int p);
        while (k % FR != p) tick(1'b0, 16'h0, lz_cur);
    endtask

    task automatic start();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        k = 0;
        m_act = '0;
        m_sh = '0;
        m_pend = 1'b0;
        drive(1'b0, 16'h0, lz_cur);
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() >= 2) begin
            exp_t e;
            e = q.pop_front();
            nmon++;
            nchk++;
            if ({bus.seg, bus.dig_en, bus.frame_done} !== {e.seg, e.dig, e.fd}) begin
                nfail++;
                $display("FAIL out cycle %0d: got seg=%b dig_en=%b fd=%b expected seg=%b dig_en=%b fd=%b",
                         e.cyc, bus.seg, bus.dig_en, bus.frame_done, e.seg, e.dig, e.fd);
            end
        end
    end

    initial begin
        bus.load = 1'b0;
        bus.bcd_in = '0;
        bus.lz_blank_en = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_seg", bus.seg, 0);
        chk("reset_dig_en", bus.dig_en, 0);
        chk("reset_frame_done", bus.frame_done, 0);
        start();
        idle_to(4);
        tick(1'b1, 16'h1234, 1'b0);
        idle(3 * FR);
        idle_to(11);
        tick(1'b1, 16'h5678, 1'b0);
        idle_to(21);
        tick(1'b1, 16'h0009, 1'b0);
        idle(2 * FR);
        idle_to(21);
        tick(1'b1, 16'h7777, 1'b0);
        idle_to(0);
        tick(1'b1, 16'h4321, 1'b0);
        idle(2 * FR);
        idle_to(5);
        tick(1'b1, 16'h0040, 1'b1);
        idle(2 * FR);
        idle_to(5);
        tick(1'b1, 16'h0000, 1'b1);
        idle(2 * FR);
        idle_to(5);
        tick(1'b1, 16'h34C5, 1'b0);
        idle(2 * FR);
        idle_to(5);
        tick(1'b1, 16'h1234, 1'b0);
        idle(FR);
        idle_to(14);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        ndrop += q.size();
        q.delete();
        #1;
        chk("async_reset_seg", bus.seg, 0);
        chk("async_reset_dig_en", bus.dig_en, 0);
        chk("async_reset_frame_done", bus.frame_done, 0);
        repeat (2) @(posedge clk);
        start();
        idle(FR + 4);
        repeat (400) begin
            logic [15:0] v;
            for (int i = 0; i < 4; i++)
                v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            tick($urandom_range(0, 7) == 0, v, ($urandom_range(0, 15) == 0) ? ~lz_cur : lz_cur);
        end
        @(negedge clk);
        #1;
        chk("monitor_count", nmon, npush - ndrop - q.size());
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
